// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (FETCH/DECODE/EXECUTE/WRITEBACK) that drives
// the ALU function select, register-file addresses and write enable.
module alu_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] HALT_OP  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       imem_rd_en,
  output logic [7:0] pc,
  input  logic [7:0] imem_data,
  output logic [2:0] alu_control,
  output logic [1:0] rf_ra1,
  output logic [1:0] rf_ra2,
  output logic [1:0] rf_wa,
  output logic       rf_we,
  input  logic       alu_zero,
  output logic       zero_flag,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  state_t     r_state;
  logic [7:0] r_pc;
  logic [7:0] r_ir;
  logic       r_rd_en;
  logic       r_we;
  logic       r_zf;
  logic       r_busy;
  logic       r_halted;
  logic       w_drive_alu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= 8'h00;
      r_rd_en  <= 1'b0;
      r_we     <= 1'b0;
      r_zf     <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            r_pc     <= RESET_PC;
            r_rd_en  <= 1'b1;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_rd_en <= 1'b0;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_ir <= imem_data;
          if (imem_data == HALT_OP) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALTED;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          // Skip decision uses the flag left by the previous instruction
          r_we    <= ~(r_ir[0] & r_zf);
          r_state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (r_we) r_zf <= alu_zero;
          r_we    <= 1'b0;
          r_pc    <= r_pc + 8'd1;
          r_rd_en <= 1'b1;
          r_state <= S_FETCH;
        end
        default: begin
          r_rd_en  <= 1'b0;
          r_we     <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Operand/function fields come from the latched instruction, held through writeback
  assign w_drive_alu = (r_state == S_EXECUTE) || (r_state == S_WRITEBACK);

  assign alu_control = w_drive_alu ? r_ir[7:5] : 3'd0;
  assign rf_ra1      = w_drive_alu ? r_ir[4:3] : 2'd0;
  assign rf_ra2      = w_drive_alu ? r_ir[2:1] : 2'd0;
  assign rf_wa       = w_drive_alu ? r_ir[4:3] : 2'd0;
  assign rf_we       = r_we;
  assign imem_rd_en  = r_rd_en;
  assign pc          = r_pc;
  assign zero_flag   = r_zf;
  assign busy        = r_busy;
  assign halted      = r_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction memory and ALU-zero source, with an
// instruction-level reference model tracking pc and the sticky zero flag.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       imem_rd_en;
  logic [7:0] pc;
  logic [7:0] imem_data;
  logic [2:0] alu_control;
  logic [1:0] rf_ra1, rf_ra2, rf_wa;
  logic       rf_we;
  logic       alu_zero;
  logic       zero_flag;
  logic       busy;
  logic       halted;

  logic [7:0] mem   [256];
  logic       zbits [256];

  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_pc;
  logic       m_zf;

  alu_sequencer #(.RESET_PC(8'h00), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd_en(imem_rd_en), .pc(pc), .imem_data(imem_data),
    .alu_control(alu_control), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
    .rf_wa(rf_wa), .rf_we(rf_we), .alu_zero(alu_zero),
    .zero_flag(zero_flag), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the read strobe
  always @(posedge clk) if (imem_rd_en) imem_data <= mem[pc];

  assign alu_zero = zbits[pc];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] v;
    v = 8'($urandom);
    while (v == 8'hFF) v = 8'($urandom);
    return v;
  endfunction

  task automatic do_reset;
    start = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_pc = 8'h00;
    m_zf = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    step();
    start = 1'b0;
    m_pc = 8'h00;
  endtask

  // Walks one instruction through its phases; returns with the DUT in the next FETCH or HALTED
  task automatic run_instr(input logic noise, output logic was_halt);
    logic [7:0] ins;
    logic       exp_we;
    ins = mem[m_pc];
    was_halt = 1'b0;
    start = noise;
    checks++;
    if (imem_rd_en !== 1'b1 || pc !== m_pc || busy !== 1'b1 || halted !== 1'b0 ||
        rf_we !== 1'b0 || alu_control !== 3'd0 || rf_wa !== 2'd0 || zero_flag !== m_zf) begin
      failures++;
      $display("FAIL fetch: got rd_en=%b pc=%h busy=%b halted=%b we=%b alu=%0d wa=%0d zf=%b, need rd_en=1 pc=%h busy=1 halted=0 we=0 alu=0 wa=0 zf=%b",
               imem_rd_en, pc, busy, halted, rf_we, alu_control, rf_wa, zero_flag, m_pc, m_zf);
    end
    step();
    start = noise;
    checks++;
    if (imem_rd_en !== 1'b0 || pc !== m_pc || busy !== 1'b1 || rf_we !== 1'b0 ||
        alu_control !== 3'd0 || rf_ra1 !== 2'd0 || rf_ra2 !== 2'd0) begin
      failures++;
      $display("FAIL decode: got rd_en=%b pc=%h busy=%b we=%b alu=%0d ra1=%0d ra2=%0d, need rd_en=0 pc=%h busy=1 we=0 alu=0 ra1=0 ra2=0",
               imem_rd_en, pc, busy, rf_we, alu_control, rf_ra1, rf_ra2, m_pc);
    end
    step();
    if (ins == 8'hFF) begin
      start = 1'b0;
      was_halt = 1'b1;
      checks++;
      if (halted !== 1'b1 || busy !== 1'b0 || pc !== m_pc || rf_we !== 1'b0 ||
          imem_rd_en !== 1'b0 || alu_control !== 3'd0) begin
        failures++;
        $display("FAIL halt_entry: got halted=%b busy=%b pc=%h we=%b rd_en=%b alu=%0d, need halted=1 busy=0 pc=%h we=0 rd_en=0 alu=0",
                 halted, busy, pc, rf_we, imem_rd_en, alu_control, m_pc);
      end
      return;
    end
    start = noise;
    checks++;
    if (alu_control !== ins[7:5] || rf_ra1 !== ins[4:3] || rf_ra2 !== ins[2:1] ||
        rf_wa !== ins[4:3] || rf_we !== 1'b0 || busy !== 1'b1 || imem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL execute: got alu=%0d ra1=%0d ra2=%0d wa=%0d we=%b busy=%b rd_en=%b, need alu=%0d ra1=%0d ra2=%0d wa=%0d we=0 busy=1 rd_en=0",
               alu_control, rf_ra1, rf_ra2, rf_wa, rf_we, busy, imem_rd_en,
               ins[7:5], ins[4:3], ins[2:1], ins[4:3]);
    end
    step();
    start = noise;
    exp_we = !(ins[0] && m_zf);
    checks++;
    if (rf_we !== exp_we || alu_control !== ins[7:5] || rf_ra1 !== ins[4:3] ||
        rf_ra2 !== ins[2:1] || rf_wa !== ins[4:3] || pc !== m_pc || imem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL writeback: got we=%b alu=%0d ra1=%0d ra2=%0d wa=%0d pc=%h rd_en=%b, need we=%b alu=%0d ra1=%0d ra2=%0d wa=%0d pc=%h rd_en=0",
               rf_we, alu_control, rf_ra1, rf_ra2, rf_wa, pc, imem_rd_en,
               exp_we, ins[7:5], ins[4:3], ins[2:1], ins[4:3], m_pc);
    end
    if (exp_we) m_zf = zbits[m_pc];
    m_pc = m_pc + 8'd1;
    step();
    start = 1'b0;
  endtask

  task automatic run_program(input logic noise, input int max_instr);
    logic h;
    for (int i = 0; i < max_instr; i++) begin
      run_instr(noise, h);
      if (h) break;
    end
  endtask

  task automatic test_reset;
    start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (imem_rd_en !== 1'b0 || pc !== 8'h00 || alu_control !== 3'd0 || rf_ra1 !== 2'd0 ||
        rf_ra2 !== 2'd0 || rf_wa !== 2'd0 || rf_we !== 1'b0 || zero_flag !== 1'b0 ||
        busy !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got rd_en=%b pc=%h alu=%0d ra1=%0d ra2=%0d wa=%0d we=%b zf=%b busy=%b halted=%b, need all zero",
               imem_rd_en, pc, alu_control, rf_ra1, rf_ra2, rf_wa, rf_we, zero_flag, busy, halted);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || imem_rd_en !== 1'b0 || pc !== 8'h00 || halted !== 1'b0) begin
      failures++;
      $display("FAIL idle_wait: got busy=%b rd_en=%b pc=%h halted=%b, need busy=0 rd_en=0 pc=00 halted=0",
               busy, imem_rd_en, pc, halted);
    end
    m_pc = 8'h00;
    m_zf = 1'b0;
  endtask

  task automatic test_reset_mid_exec;
    do_reset();
    mem[0] = 8'b101_10_11_0;
    mem[1] = 8'hFF;
    zbits[0] = 1'b1;
    do_start();
    step();
    step();
    checks++;
    if (alu_control !== 3'b101 || rf_ra1 !== 2'd2) begin
      failures++;
      $display("FAIL mid_exec_setup: got alu=%0d ra1=%0d, need alu=5 ra1=2", alu_control, rf_ra1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (alu_control !== 3'd0 || rf_ra1 !== 2'd0 || rf_ra2 !== 2'd0 || rf_wa !== 2'd0 ||
        rf_we !== 1'b0 || busy !== 1'b0 || pc !== 8'h00 || imem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_exec_abort: got alu=%0d ra1=%0d ra2=%0d wa=%0d we=%b busy=%b pc=%h rd_en=%b, need all zero",
               alu_control, rf_ra1, rf_ra2, rf_wa, rf_we, busy, pc, imem_rd_en);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (rf_we !== 1'b0 || zero_flag !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_exec_no_write: got we=%b zf=%b busy=%b, need we=0 zf=0 busy=0", rf_we, zero_flag, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0 || imem_rd_en !== 1'b0 || rf_we !== 1'b0 || pc !== 8'h00) begin
      failures++;
      $display("FAIL mid_exec_idle: got busy=%b rd_en=%b we=%b pc=%h, need busy=0 rd_en=0 we=0 pc=00",
               busy, imem_rd_en, rf_we, pc);
    end
    m_pc = 8'h00;
    m_zf = 1'b0;
  endtask

  task automatic test_single_add;
    do_reset();
    mem[0] = 8'b000_01_10_0;
    mem[1] = 8'hFF;
    zbits[0] = 1'($urandom);
    do_start();
    run_program(1'b0, 4);
  endtask

  task automatic test_skip;
    do_reset();
    mem[0] = 8'b001_00_00_0;
    zbits[0] = 1'b1;
    mem[1] = 8'b110_01_01_1;
    zbits[1] = 1'b0;
    mem[2] = 8'hFF;
    do_start();
    run_program(1'b0, 4);
    checks++;
    if (zero_flag !== 1'b1) begin
      failures++;
      $display("FAIL skip_flag_sticky: got zf=%b, need zf=1", zero_flag);
    end
  endtask

  task automatic test_halt_restart;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem[i] = rand_op();
      zbits[i] = 1'($urandom);
    end
    mem[3] = 8'hFF;
    do_start();
    run_program(1'b0, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (halted !== 1'b1 || pc !== 8'h03 || rf_we !== 1'b0 || imem_rd_en !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold: got halted=%b pc=%h we=%b rd_en=%b busy=%b, need halted=1 pc=03 we=0 rd_en=0 busy=0",
                 halted, pc, rf_we, imem_rd_en, busy);
      end
    end
    do_start();
    run_program(1'b0, 5);
  endtask

  task automatic test_random_programs;
    int len;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        mem[i] = rand_op();
        zbits[i] = 1'($urandom);
      end
      mem[len] = 8'hFF;
      do_start();
      run_program(1'b0, 24);
    end
  endtask

  task automatic test_pc_wrap;
    logic h;
    for (int i = 0; i < 256; i++) begin
      mem[i] = rand_op();
      zbits[i] = 1'($urandom);
    end
    do_start();
    run_instr(1'b0, h);
    mem[0] = 8'hFF;
    for (int i = 1; i < 256; i++) run_instr(1'b0, h);
    checks++;
    if (pc !== 8'h00 || imem_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL pc_wrap: got pc=%h rd_en=%b, need pc=00 rd_en=1", pc, imem_rd_en);
    end
    run_instr(1'b0, h);
  endtask

  task automatic test_start_while_busy;
    for (int i = 0; i < 6; i++) begin
      mem[i] = rand_op();
      zbits[i] = 1'($urandom);
    end
    mem[6] = 8'hFF;
    do_start();
    run_program(1'b1, 8);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    imem_data = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'hFF;
      zbits[i] = 1'b0;
    end
    test_reset();
    test_reset_mid_exec();
    test_single_add();
    test_skip();
    test_halt_restart();
    test_random_programs();
    test_pc_wrap();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit that fetches 8-bit instructions, decodes them and drives the 3-bit ALU function select, register-file addresses and write enable.
- Sits between instruction memory, register file and the 8-bit ALU, which it drives as the controlling end.
- Holds the program counter and a sticky zero flag for conditional writeback.
- Each instruction takes 4 cycles: FETCH, DECODE, EXECUTE, WRITEBACK.

Parameters:
RESET_PC  8'h00  PC value loaded on reset and on every accepted start
HALT_OP   8'hFF  instruction encoding treated as HALT (not executed as an ALU op)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins execution from IDLE or HALTED
imem_rd_en  output  1  instruction read strobe; memory returns data the next cycle
pc  output  8  instruction address
imem_data  input  8  instruction word, valid the cycle after imem_rd_en
alu_control  output  3  ALU function select: 000 add, 001 sub, 010 not, 011 shl, 100 shr, 101 and, 110 or, 111 slt
rf_ra1  output  2  register-file read address, operand a
rf_ra2  output  2  register-file read address, operand b
rf_wa  output  2  register-file write address
rf_we  output  1  register-file write enable; the ALU result is written on the clk edge while this signal is high
alu_zero  input  1  zero output of the ALU, combinational from current operands and function
zero_flag  output  1  sticky zero flag from the last completed write
busy  output  1  high in FETCH, DECODE, EXECUTE and WRITEBACK
halted  output  1  high in HALTED

Behaviour:
- Instruction format: ir[7:5] is the ALU op, ir[4:3] is rd and also the rs1 source, ir[2:1] is rs2, ir[0] is skip_if_zero.
- Reset (asynchronous, rst_n low):
  - state=IDLE, pc=RESET_PC, ir=0.
  - Outputs: alu_control=0, rf_ra1=0, rf_ra2=0, rf_wa=0, rf_we=0, imem_rd_en=0, zero_flag=0, busy=0, halted=0.
  - A reset asserted mid-instruction aborts it immediately; no write occurs.
- IDLE: wait for start. On start, pc<=RESET_PC and go to FETCH.
- FETCH: imem_rd_en=1 for exactly this one cycle, with pc stable. Go to DECODE.
- DECODE: ir<=imem_data.
  - If imem_data==HALT_OP, go to HALTED; pc is not incremented.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Drive alu_control=ir[7:5], rf_ra1=ir[4:3], rf_ra2=ir[2:1], rf_wa=ir[4:3]; rf_we=0.
  - Latch the skip decision: skip = ir[0] & zero_flag, using the flag value before this instruction.
  - Go to WRITEBACK.
- WRITEBACK:
  - Hold alu_control, rf_ra1, rf_ra2 and rf_wa unchanged from EXECUTE so the ALU result is stable.
  - rf_we = ~skip.
  - If not skipped, zero_flag<=alu_zero at the end of the cycle. If skipped, zero_flag is unchanged.
  - pc<=pc+1, wrapping modulo 256 (8'hFF -> 8'h00). Go to FETCH.
- HALTED: halted=1, busy=0, all strobes low. On start, pc<=RESET_PC and go to FETCH.
- start is ignored while busy=1.
- alu_control, rf_ra1, rf_ra2 and rf_wa are 0 in IDLE, HALTED, FETCH and DECODE.
- rf_we is high only in WRITEBACK, for exactly one cycle.
- All outputs are registered or decoded from state plus registers. There is no combinational path from imem_data to any output.
- Throughput: one instruction per 4 cycles. HALT costs 2 cycles (FETCH, DECODE).

Test Plan:
- Reset mid-EXECUTE, with rst_n low for 1 cycle → all outputs return to reset values immediately; state=IDLE; no rf_we pulse; pc=RESET_PC.
- start, with memory returning 8'b000_01_10_0 (add r1,r1,r2) at pc 0 → imem_rd_en at cycle 1; EXECUTE at cycle 3 with alu_control=000, ra1=1, ra2=2; rf_we=1 at cycle 4 with wa=1; pc=1 after.
- Program [8'b001_00_00_0 (sub r0,r0,r0), 8'b110_01_01_1 (or r1,r1,r1 with skip)], with alu_zero=1 on the first instruction → zero_flag=1 after the first; the second shows rf_we=0 in WRITEBACK and zero_flag stays 1.
- HALT_OP at pc 3 → halted=1 after DECODE, pc stays 3, no rf_we. start then restarts: pc=0, FETCH next cycle.
- Preload pc=8'hFF with a non-halt op at 8'hFF → after WRITEBACK pc=8'h00, with no glitch on imem_rd_en.
- Pulse start while busy=1 in every state → no effect on pc or state; sequence timing unchanged.
